// File: rtl/mix_product_accumulator.sv
// mix_product_accumulator: sums 8-bit (a+b)*(c+d) product beats into a
// saturating packet total. A packet closes on an in_last beat or on the
// MAX_COUNT-th beat. The closed result is held until the consumer takes it.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr           synchronous abort of the packet or held result
//   in_valid      product beat valid
//   in_ready      beat accepted when high (depends only on state)
//   in_product    8-bit product beat
//   in_last       final beat of the packet
//   out_valid     packet result valid
//   out_ready     consumer accepts the result
//   out_sum       saturated packet sum
//   out_count     number of beats in the packet
//   out_overflow  sum saturated somewhere in the packet
module mix_product_accumulator #(
  parameter int unsigned ACC_W     = 10,
  parameter int unsigned MAX_COUNT = 8,
  localparam int unsigned CNT_W    = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0] sum_sat;
  logic             clamp;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             close;

  // Beat arithmetic: one extra bit catches the carry used for saturation.
  always_comb begin
    sum_ext = {1'b0, acc_q} + SUM_W'(in_product);
    clamp   = sum_ext[ACC_W];
    sum_sat = clamp ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    cnt_inc = cnt_q + CNT_W'(1);
    // clr drops any beat presented alongside it
    accept  = in_valid & in_ready & ~clr;
    // in_last and the count limit on the same beat still close only once
    close   = accept & (in_last | (cnt_inc == CNT_MAX));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clr wins over close and hand-off.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_ACC;
    end else begin
      unique case (state_q)
        ST_ACC: if (close)     state_d = ST_OUT;
        ST_OUT: if (out_ready) state_d = ST_ACC;
        default:               state_d = ST_ACC;
      endcase
    end
  end

  // Handshake outputs decode the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_ACC:  in_ready  = 1'b1;
      ST_OUT:  out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  // Accumulator and result register next values.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (close) begin
      out_sum_d   = sum_sat;
      out_count_d = cnt_inc;
      out_ovf_d   = ovf_q | clamp;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end else if (accept) begin
      acc_d = sum_sat;
      cnt_d = cnt_inc;
      ovf_d = ovf_q | clamp;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_sum      = out_sum_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_mix_product_accumulator.sv
// Testbench for mix_product_accumulator: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// packet-level model.
module tb_mix_product_accumulator;

  localparam int ACC_W     = 10;
  localparam int MAX_COUNT = 8;
  localparam int CNT_W     = 4;
  localparam int ACC_MAX   = 1023;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_product = 8'd0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  mix_product_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: running total, beat count, sticky overflow, and
  // whether a closed result is waiting for the consumer.
  bit m_busy = 1'b0;
  int m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  int e_sum = 0;
  int e_cnt = 0;
  bit e_ovf = 1'b0;
  int m_s;
  bit m_sat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      e_sum = 0; e_cnt = 0; e_ovf = 1'b0;
    end else if (clr) begin
      m_busy = 1'b0; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_s   = m_acc + int'(in_product);
        m_sat = (m_s > ACC_MAX);
        if (m_sat) m_s = ACC_MAX;
        m_cnt = m_cnt + 1;
        m_ovf = m_ovf | m_sat;
        if (in_last || m_cnt == MAX_COUNT) begin
          e_sum = m_s; e_cnt = m_cnt; e_ovf = m_ovf;
          m_busy = 1'b1; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        end else begin
          m_acc = m_s;
        end
      end
    end else if (out_ready) begin
      m_busy = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(!m_busy));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_busy));
      if (m_busy) begin
        chk("cyc_out_sum", 32'(out_sum), 32'(e_sum));
        chk("cyc_out_count", 32'(out_count), 32'(e_cnt));
        chk("cyc_out_overflow", 32'(out_overflow), 32'(e_ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic send(input int p, input bit l);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_product = 8'(p);
    in_last = l;
    for (int k = 0; k < 40 && !done; k++) begin
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0d not accepted within 40 cycles", p);
    end
  endtask

  initial begin
    // Reset with a beat presented: nothing may be accepted.
    in_valid = 1'b1; in_product = 8'd33; in_last = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_overflow", 32'(out_overflow), 32'd0);
    in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // Short packet 10+20+30.
    out_ready = 1'b1;
    send(10, 0); send(20, 0); send(30, 1);
    chk("short_valid", 32'(out_valid), 32'd1);
    chk("short_sum", 32'(out_sum), 32'd60);
    chk("short_count", 32'(out_count), 32'd3);
    chk("short_ovf", 32'(out_overflow), 32'd0);
    tick();
    chk("short_valid_drop", 32'(out_valid), 32'd0);

    // Saturation and auto-close at MAX_COUNT.
    for (int i = 0; i < 8; i++) send(200, 0);
    chk("sat_valid", 32'(out_valid), 32'd1);
    chk("sat_sum", 32'(out_sum), 32'd1023);
    chk("sat_count", 32'(out_count), 32'd8);
    chk("sat_ovf", 32'(out_overflow), 32'd1);
    tick();
    send(5, 1);
    chk("after_sat_sum", 32'(out_sum), 32'd5);
    chk("after_sat_count", 32'(out_count), 32'd1);
    chk("after_sat_ovf", 32'(out_overflow), 32'd0);
    tick();

    // Backpressure: result held, new beat refused.
    out_ready = 1'b0;
    send(7, 1);
    in_valid = 1'b1; in_product = 8'd99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_sum", 32'(out_sum), 32'd7);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    send(4, 1);
    chk("bp_next_sum", 32'(out_sum), 32'd4);
    chk("bp_next_count", 32'(out_count), 32'd1);
    tick();

    // Abort mid-packet; the beat alongside clr is dropped.
    send(50, 0); send(60, 0);
    clr = 1'b1; in_valid = 1'b1; in_product = 8'd70; in_last = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    send(5, 1);
    chk("abort_sum", 32'(out_sum), 32'd5);
    chk("abort_count", 32'(out_count), 32'd1);
    tick();

    // Abort a held result.
    out_ready = 1'b0;
    send(9, 1);
    chk("clr_out_pre", 32'(out_valid), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_out_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset while a result is held.
    send(11, 1);
    chk("arst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_sum", 32'(out_sum), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(3, 1);
    chk("arst_next_sum", 32'(out_sum), 32'd3);
    chk("arst_next_count", 32'(out_count), 32'd1);
    tick();

    // Randomized traffic, checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom % 10) < 7;
      in_product = (($urandom % 4) == 0) ? 8'($urandom_range(180, 255))
                                         : 8'($urandom_range(0, 255));
      in_last    = ($urandom % 4) == 0;
      out_ready  = ($urandom % 10) < 6;
      clr        = ($urandom % 40) == 0;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
